// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM port arbiter: FSM encoding and
// the busy-flag timeout used before a start trigger is re-issued.
package sdram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        RETURN
    } state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    localparam int unsigned BUSY_TIMEOUT = 8;
    localparam int unsigned BUSY_CNT_W   = $clog2(BUSY_TIMEOUT);

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. Holds the last-grant pointer, which
// resets to port B so that port A wins the first tie.
module rr_arbiter2
    import sdram_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  en_i,
    input  logic  req_a_i,
    input  logic  req_b_i,
    output logic  gnt_o,
    output port_e gnt_port_o
);

    port_e last_q, last_d;

    always_comb begin
        gnt_o      = en_i && (req_a_i || req_b_i);
        gnt_port_o = (req_b_i && (!req_a_i || last_q == PORT_A)) ? PORT_B : PORT_A;
        last_d     = last_q;
        if (gnt_o) begin
            last_d = gnt_port_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_q <= PORT_B;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Arbitrates two read/write request ports onto one SDRAM controller and
// returns read data to the granted port. All outputs are registered.
module sdram_port_arbiter
    import sdram_pkg::*;
#(
    parameter int ADR_W = 24,
    parameter int DAT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             a_rd_req,
    input  logic             a_wt_req,
    input  logic [ADR_W-1:0] a_adr,
    input  logic [DAT_W-1:0] a_wdata,
    output logic             a_ack,
    output logic [DAT_W-1:0] a_rd_data,
    output logic             a_rd_stb,
    input  logic             a_rd_ack,
    input  logic             b_rd_req,
    input  logic             b_wt_req,
    input  logic [ADR_W-1:0] b_adr,
    input  logic [DAT_W-1:0] b_wdata,
    output logic             b_ack,
    output logic [DAT_W-1:0] b_rd_data,
    output logic             b_rd_stb,
    input  logic             b_rd_ack,
    output logic             rd_start_trig,
    output logic             wt_start_trig,
    output logic [ADR_W-1:0] sd_adr,
    output logic [DAT_W-1:0] sd_wdata,
    input  logic             rd_busy_flag,
    input  logic             wt_busy_flag,
    input  logic             rd_o_stb,
    input  logic             wt_o_stb,
    output logic             rd_o_ack,
    output logic             wt_o_ack,
    input  logic [DAT_W-1:0] RD_DATA
);

    state_e                state_q, state_d;
    port_e                 port_q, port_d;
    logic                  op_rd_q, op_rd_d;
    logic [BUSY_CNT_W-1:0] cnt_q, cnt_d;
    logic [ADR_W-1:0]      sd_adr_q, sd_adr_d;
    logic [DAT_W-1:0]      sd_wdata_q, sd_wdata_d;
    logic [DAT_W-1:0]      rdata_q, rdata_d;
    logic                  a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic                  a_stb_q, a_stb_d, b_stb_q, b_stb_d;
    logic                  rd_trig_q, rd_trig_d, wt_trig_q, wt_trig_d;
    logic                  rd_oack_q, rd_oack_d, wt_oack_q, wt_oack_d;

    logic  arb_en, gnt;
    port_e gnt_port;

    assign arb_en = (state_q == IDLE) && !rd_busy_flag && !wt_busy_flag;

    rr_arbiter2 u_rr (
        .clk_i      (CLK),
        .rst_ni     (RST),
        .en_i       (arb_en),
        .req_a_i    (a_rd_req || a_wt_req),
        .req_b_i    (b_rd_req || b_wt_req),
        .gnt_o      (gnt),
        .gnt_port_o (gnt_port)
    );

    always_comb begin
        state_d    = state_q;
        port_d     = port_q;
        op_rd_d    = op_rd_q;
        cnt_d      = cnt_q;
        sd_adr_d   = sd_adr_q;
        sd_wdata_d = sd_wdata_q;
        rdata_d    = rdata_q;
        a_stb_d    = a_stb_q;
        b_stb_d    = b_stb_q;
        a_ack_d    = 1'b0;
        b_ack_d    = 1'b0;
        rd_trig_d  = 1'b0;
        wt_trig_d  = 1'b0;
        rd_oack_d  = 1'b0;
        wt_oack_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt) begin
                    port_d = gnt_port;
                    // A port raising both strobes gets its read first; the write stays pending.
                    if (gnt_port == PORT_B) begin
                        op_rd_d    = b_rd_req;
                        sd_adr_d   = b_adr;
                        sd_wdata_d = b_wdata;
                        b_ack_d    = 1'b1;
                    end else begin
                        op_rd_d    = a_rd_req;
                        sd_adr_d   = a_adr;
                        sd_wdata_d = a_wdata;
                        a_ack_d    = 1'b1;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                rd_trig_d = op_rd_q;
                wt_trig_d = !op_rd_q;
                cnt_d     = '0;
                state_d   = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (op_rd_q ? rd_busy_flag : wt_busy_flag) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == BUSY_CNT_W'(BUSY_TIMEOUT - 1)) begin
                    state_d = ISSUE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (op_rd_q) begin
                    if (rd_o_stb) begin
                        rdata_d   = RD_DATA;
                        rd_oack_d = 1'b1;
                        a_stb_d   = (port_q == PORT_A);
                        b_stb_d   = (port_q == PORT_B);
                        state_d   = RETURN;
                    end
                end else if (wt_o_stb) begin
                    wt_oack_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            RETURN: begin
                if ((port_q == PORT_B) ? b_rd_ack : a_rd_ack) begin
                    a_stb_d = 1'b0;
                    b_stb_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= IDLE;
            port_q     <= PORT_A;
            op_rd_q    <= 1'b0;
            cnt_q      <= '0;
            sd_adr_q   <= '0;
            sd_wdata_q <= '0;
            rdata_q    <= '0;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            a_stb_q    <= 1'b0;
            b_stb_q    <= 1'b0;
            rd_trig_q  <= 1'b0;
            wt_trig_q  <= 1'b0;
            rd_oack_q  <= 1'b0;
            wt_oack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            port_q     <= port_d;
            op_rd_q    <= op_rd_d;
            cnt_q      <= cnt_d;
            sd_adr_q   <= sd_adr_d;
            sd_wdata_q <= sd_wdata_d;
            rdata_q    <= rdata_d;
            a_ack_q    <= a_ack_d;
            b_ack_q    <= b_ack_d;
            a_stb_q    <= a_stb_d;
            b_stb_q    <= b_stb_d;
            rd_trig_q  <= rd_trig_d;
            wt_trig_q  <= wt_trig_d;
            rd_oack_q  <= rd_oack_d;
            wt_oack_q  <= wt_oack_d;
        end
    end

    assign a_ack         = a_ack_q;
    assign b_ack         = b_ack_q;
    assign a_rd_stb      = a_stb_q;
    assign b_rd_stb      = b_stb_q;
    assign a_rd_data     = rdata_q;
    assign b_rd_data     = rdata_q;
    assign rd_start_trig = rd_trig_q;
    assign wt_start_trig = wt_trig_q;
    assign rd_o_ack      = rd_oack_q;
    assign wt_o_ack      = wt_oack_q;
    assign sd_adr        = sd_adr_q;
    assign sd_wdata      = sd_wdata_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter; the bench itself plays the
// SDRAM controller and both requesters.
module tb_sdram_port_arbiter;

    localparam int ADR_W = 24;
    localparam int DAT_W = 16;

    logic             CLK = 1'b0;
    logic             RST;
    logic             a_rd_req, a_wt_req, a_rd_ack;
    logic             b_rd_req, b_wt_req, b_rd_ack;
    logic [ADR_W-1:0] a_adr, b_adr;
    logic [DAT_W-1:0] a_wdata, b_wdata;
    logic             a_ack, b_ack, a_rd_stb, b_rd_stb;
    logic [DAT_W-1:0] a_rd_data, b_rd_data;
    logic             rd_start_trig, wt_start_trig;
    logic [ADR_W-1:0] sd_adr;
    logic [DAT_W-1:0] sd_wdata;
    logic             rd_busy_flag, wt_busy_flag, rd_o_stb, wt_o_stb;
    logic             rd_o_ack, wt_o_ack;
    logic [DAT_W-1:0] RD_DATA;

    int checks   = 0;
    int failures = 0;
    int rd_pulses = 0;
    int wt_pulses = 0;
    int p_rd, p_wt;

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (rd_start_trig) rd_pulses++;
        if (wt_start_trig) wt_pulses++;
    end

    sdram_port_arbiter #(.ADR_W(ADR_W), .DAT_W(DAT_W)) dut (
        .CLK(CLK), .RST(RST),
        .a_rd_req(a_rd_req), .a_wt_req(a_wt_req), .a_adr(a_adr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rd_data(a_rd_data), .a_rd_stb(a_rd_stb), .a_rd_ack(a_rd_ack),
        .b_rd_req(b_rd_req), .b_wt_req(b_wt_req), .b_adr(b_adr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rd_data(b_rd_data), .b_rd_stb(b_rd_stb), .b_rd_ack(b_rd_ack),
        .rd_start_trig(rd_start_trig), .wt_start_trig(wt_start_trig),
        .sd_adr(sd_adr), .sd_wdata(sd_wdata),
        .rd_busy_flag(rd_busy_flag), .wt_busy_flag(wt_busy_flag),
        .rd_o_stb(rd_o_stb), .wt_o_stb(wt_o_stb),
        .rd_o_ack(rd_o_ack), .wt_o_ack(wt_o_ack),
        .RD_DATA(RD_DATA)
    );

    task automatic step(input int unsigned n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pulses();
        return {24'd0, a_ack, b_ack, a_rd_stb, b_rd_stb,
                rd_start_trig, wt_start_trig, rd_o_ack, wt_o_ack};
    endfunction

    // Called right after an x_ack is observed; leaves the DUT in RETURN.
    task automatic serve_read(input logic [DAT_W-1:0] data, input string tag);
        step(1);
        chk({tag, "_rtrig"}, rd_start_trig, 1);
        chk({tag, "_wtrig"}, wt_start_trig, 0);
        rd_busy_flag = 1'b1;
        step(1);
        chk({tag, "_rtrig_once"}, rd_start_trig, 0);
        rd_o_stb = 1'b1;
        RD_DATA  = data;
        step(1);
        chk({tag, "_rd_o_ack"}, rd_o_ack, 1);
        rd_o_stb     = 1'b0;
        rd_busy_flag = 1'b0;
        RD_DATA      = '0;
    endtask

    // Called right after an x_ack is observed; leaves the DUT in IDLE.
    task automatic serve_write(input string tag);
        step(1);
        chk({tag, "_wtrig"}, wt_start_trig, 1);
        chk({tag, "_rtrig"}, rd_start_trig, 0);
        wt_busy_flag = 1'b1;
        step(1);
        chk({tag, "_wtrig_once"}, wt_start_trig, 0);
        wt_o_stb = 1'b1;
        step(1);
        chk({tag, "_wt_o_ack"}, wt_o_ack, 1);
        wt_o_stb     = 1'b0;
        wt_busy_flag = 1'b0;
    endtask

    initial begin
        RST = 1'b0;
        a_rd_req = 0; a_wt_req = 0; a_rd_ack = 0; a_adr = '0; a_wdata = '0;
        b_rd_req = 0; b_wt_req = 0; b_rd_ack = 0; b_adr = '0; b_wdata = '0;
        rd_busy_flag = 0; wt_busy_flag = 0; rd_o_stb = 0; wt_o_stb = 0; RD_DATA = '0;
        step(3);
        chk("rst_pulses", pulses(), 0);
        chk("rst_sd_adr", sd_adr, 0);
        chk("rst_sd_wdata", sd_wdata, 0);
        chk("rst_rd_data", {a_rd_data, b_rd_data}, 0);
        RST = 1'b1;
        step(1);

        // Single read from A, data held until a_rd_ack.
        a_rd_req = 1; a_adr = 24'h000010;
        step(1);
        chk("rd_a_ack", a_ack, 1);
        chk("rd_b_ack", b_ack, 0);
        chk("rd_sd_adr", sd_adr, 24'h000010);
        chk("rd_trig_early", rd_start_trig, 0);
        a_rd_req = 0;
        serve_read(16'hBEEF, "rd");
        chk("rd_a_stb", a_rd_stb, 1);
        chk("rd_a_data", a_rd_data, 16'hBEEF);
        chk("rd_b_stb", b_rd_stb, 0);
        step(1);
        chk("rd_o_ack_pulse", rd_o_ack, 0);
        step(1);
        chk("rd_a_stb_hold", a_rd_stb, 1);
        chk("rd_a_data_hold", a_rd_data, 16'hBEEF);
        a_rd_ack = 1;
        step(1);
        chk("rd_a_stb_off", a_rd_stb, 0);
        a_rd_ack = 0;

        // Tie after reset: A, then B; A re-requesting while B waits loses to B.
        RST = 1'b0;
        step(1);
        RST = 1'b1;
        a_wt_req = 1; a_adr = 24'h000100; a_wdata = 16'h1111;
        b_wt_req = 1; b_adr = 24'h000200; b_wdata = 16'h2222;
        step(1);
        chk("tie1_a_ack", a_ack, 1);
        chk("tie1_b_ack", b_ack, 0);
        chk("tie1_adr", sd_adr, 24'h000100);
        chk("tie1_wdata", sd_wdata, 16'h1111);
        a_wt_req = 0;
        serve_write("tie1");
        chk("tie1_adr_hold", sd_adr, 24'h000100);
        a_wt_req = 1; a_adr = 24'h000300; a_wdata = 16'h3333;
        step(1);
        chk("tie2_b_ack", b_ack, 1);
        chk("tie2_a_ack", a_ack, 0);
        chk("tie2_adr", sd_adr, 24'h000200);
        chk("tie2_wdata", sd_wdata, 16'h2222);
        b_wt_req = 0;
        serve_write("tie2");
        step(1);
        chk("tie3_a_ack", a_ack, 1);
        chk("tie3_adr", sd_adr, 24'h000300);
        a_wt_req = 0;
        serve_write("tie3");

        // Same-port rd+wt: read first, then write, one trigger each.
        p_rd = rd_pulses; p_wt = wt_pulses;
        a_rd_req = 1; a_wt_req = 1; a_adr = 24'h000040; a_wdata = 16'h5555;
        step(1);
        chk("col_rd_ack", a_ack, 1);
        a_rd_req = 0;
        serve_read(16'h1234, "col_rd");
        chk("col_rd_data", a_rd_data, 16'h1234);
        a_rd_ack = 1;
        step(1);
        chk("col_stb_off", a_rd_stb, 0);
        a_rd_ack = 0;
        step(1);
        chk("col_wt_ack", a_ack, 1);
        chk("col_wt_wdata", sd_wdata, 16'h5555);
        a_wt_req = 0;
        serve_write("col_wt");
        step(1);
        chk("col_rd_pulses", rd_pulses - p_rd, 1);
        chk("col_wt_pulses", wt_pulses - p_wt, 1);

        // Busy timeout: 8 quiet cycles in WAIT_BUSY, one ISSUE cycle, then re-trigger.
        b_wt_req = 1; b_adr = 24'h000080; b_wdata = 16'h0808;
        step(1);
        chk("to_b_ack", b_ack, 1);
        b_wt_req = 0;
        step(1);
        chk("to_trig1", wt_start_trig, 1);
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("to_quiet", wt_start_trig, 0);
        end
        step(1);
        chk("to_trig2", wt_start_trig, 1);
        wt_busy_flag = 1;
        step(1);
        wt_o_stb = 1;
        step(1);
        chk("to_wt_o_ack", wt_o_ack, 1);
        chk("to_adr_hold", sd_adr, 24'h000080);
        wt_o_stb = 0; wt_busy_flag = 0;
        step(1);

        // Reset while waiting for read completion.
        a_rd_req = 1; a_adr = 24'h000020;
        step(1);
        chk("rstm_a_ack", a_ack, 1);
        a_rd_req = 0;
        step(1);
        chk("rstm_trig", rd_start_trig, 1);
        rd_busy_flag = 1;
        step(1);
        rd_o_stb = 1; RD_DATA = 16'hDEAD; RST = 1'b0;
        step(1);
        chk("rstm_pulses", pulses(), 0);
        chk("rstm_sd_adr", sd_adr, 0);
        chk("rstm_rd_data", a_rd_data, 0);
        RST = 1'b1; rd_o_stb = 0; rd_busy_flag = 0; RD_DATA = '0;
        step(1);
        chk("rstm_quiet", pulses(), 0);

        // Backpressure: A's read data held 20 cycles, B waits.
        a_rd_req = 1; a_adr = 24'h000044;
        step(1);
        chk("bp_a_ack", a_ack, 1);
        a_rd_req = 0;
        serve_read(16'hCAFE, "bp");
        b_wt_req = 1; b_adr = 24'h000099; b_wdata = 16'h9999;
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("bp_stb", a_rd_stb, 1);
            chk("bp_data", a_rd_data, 16'hCAFE);
            chk("bp_b_ack", b_ack, 0);
            chk("bp_b_stb", b_rd_stb, 0);
        end
        a_rd_ack = 1;
        step(1);
        chk("bp_release", a_rd_stb, 0);
        a_rd_ack = 0;
        step(1);
        chk("bp_b_grant", b_ack, 1);
        chk("bp_b_adr", sd_adr, 24'h000099);
        b_wt_req = 0;
        serve_write("bp_wt");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADR_W, default 24, meaning SDRAM word address width.
REQ-002 The block SHALL have parameter DAT_W, default 16, meaning SDRAM data width.
REQ-003 The block SHALL have port CLK  in  1  the single clock for all logic.
REQ-004 The block SHALL have port RST  in  1  reset, synchronous and active-low.
REQ-005 The block SHALL have ports a_rd_req, a_wt_req  in  1 each  port A read/write request strobes.
REQ-006 The block SHALL have ports a_adr  in  ADR_W and a_wdata  in  DAT_W  port A address and write data.
REQ-007 The block SHALL have port a_ack  out  1  port A request accepted (one-cycle pulse).
REQ-008 The block SHALL have ports a_rd_data  out  DAT_W and a_rd_stb  out  1  port A returned read data and its valid signal.
REQ-009 The block SHALL have port a_rd_ack  in  1  port A consumed the returned read data.
REQ-010 The block SHALL have port B signals b_* identical to REQ-005..REQ-009.
REQ-011 The block SHALL have ports rd_start_trig, wt_start_trig  out  1 each  controller start pulses.
REQ-012 The block SHALL have ports sd_adr  out  ADR_W and sd_wdata  out  DAT_W  address and write data, shared by the controller RD_ADR/WT_ADR and WT_DATA.
REQ-013 The block SHALL have ports rd_busy_flag, wt_busy_flag  in  1 each  controller busy indicators.
REQ-014 The block SHALL have ports rd_o_stb, wt_o_stb  in  1 and rd_o_ack, wt_o_ack  out  1  controller completion handshake.
REQ-015 The block SHALL have port RD_DATA  in  DAT_W  controller read data.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RETURN.
REQ-017 IDLE SHALL grant only when rd_busy_flag=0, wt_busy_flag=0 and at least one port requests.
- Both ports requesting: the port not granted last wins (round robin).
- One port asserting both rd and wt: the read wins; the write stays pending.
REQ-018 On grant the block SHALL, in the same edge:
- latch adr, wdata, op and port ID into sd_adr/sd_wdata and internal registers;
- pulse the granted x_ack for one cycle;
- update the last-grant pointer;
- enter ISSUE.
REQ-019 ISSUE SHALL pulse exactly one of rd_start_trig or wt_start_trig for one cycle, per the latched op, then enter WAIT_BUSY.
REQ-020 WAIT_BUSY SHALL wait for the matching busy flag to be high, then enter WAIT_DONE.
REQ-021 If the busy flag stays low for 8 cycles, WAIT_BUSY SHALL return to ISSUE and re-pulse the trigger.
REQ-022 WAIT_DONE, on read, SHALL wait for rd_o_stb, capture RD_DATA, hold rd_o_ack high for one cycle, and enter RETURN.
REQ-023 WAIT_DONE, on write, SHALL wait for wt_o_stb, hold wt_o_ack high for one cycle, and enter IDLE.
REQ-024 RETURN SHALL hold the granted x_rd_stb=1 with stable x_rd_data until x_rd_ack=1 in the same cycle.
- It then deasserts x_rd_stb on the next edge and enters IDLE.
- The other port's rd_stb stays 0 throughout.
REQ-025 sd_adr and sd_wdata SHALL remain stable from grant until return to IDLE.
REQ-026 Requests arriving while not in IDLE SHALL be ignored until IDLE; requesters hold strobes until x_ack.
REQ-027 Minimum request-to-x_ack latency SHALL be 1 cycle; x_ack to start trigger SHALL be 1 cycle.

Reset
REQ-028 While RST=0 at a clock edge, the block SHALL enter IDLE and drive all outputs to 0.
REQ-029 The last-grant pointer SHALL reset to B, so that A wins the first tie.
REQ-030 Reset mid-operation SHALL abandon the transfer without issuing any ack or rd_stb.

Structure
REQ-031 FSM state encoding and the busy-timeout constant (8) SHALL live in the shared package sdram_pkg.
REQ-032 The round-robin pointer and grant logic SHALL be one sub-module, rr_arbiter2.

Verification
REQ-033 Single read: A reads adr 0x000010 and the controller returns 0xBEEF. Required response:
- a_ack 1 cycle after the request;
- rd_start_trig 1 cycle after a_ack;
- a_rd_stb with a_rd_data=0xBEEF, held until a_rd_ack.
REQ-034 Tie: A and B both write in the same cycle after reset. Required order: A then B. Repeated tie: B then A.
REQ-035 Same-port collision: A asserts rd and wt together. Required: read serviced first, then write, with no extra start pulses.
REQ-036 Busy timeout: the controller ignores the first wt_start_trig. Required: trigger re-pulsed after 8 cycles, then normal completion.
REQ-037 Reset mid-transfer: RST=0 in WAIT_DONE. Required: all outputs 0 next cycle, and the next request is granted normally.
REQ-038 Backpressure: a_rd_ack held low for 20 cycles. Required: a_rd_stb and data stable, and B not granted until the release.
